ais_hdlc_receiver: RTL
======================

Name: ais_hdlc_receiver

Overview:
- Receive end of the AIS HDLC link: takes the recovered serial bit stream plus a bit strobe, and detects 0x7E flags.
- Removes stuffed zeros, assembles LSB-first octets, and checks the CRC-16/X-25 FCS.
- Emits each octet with frame start/end markers and a per-frame status word; sits between the bit-clock recovery and the NMEA/AIS message parser.

Parameters:
MAX_BYTES, 64, maximum octets per frame between flags, FCS included (AIS payload 21 + FCS 2 fits).
MIN_BYTES, 4, minimum octets per frame, FCS included; shorter frames are reported as len_err.

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-high reset.
rx_bit  input  1  recovered line bit; sampled only when rx_bit_en=1.
rx_bit_en  input  1  one-cycle bit strobe; may be high every cycle.
rx_data  output  8  assembled octet, LSB = first bit received.
rx_valid  output  1  one-cycle pulse, rx_data valid.
rx_sof  output  1  high with rx_valid on the first octet of a frame.
rx_eof  output  1  one-cycle pulse, frame ended; status outputs valid this cycle.
frame_ok  output  1  with rx_eof: CRC good, aligned, length in range.
crc_err  output  1  with rx_eof: residue != 0xF0B8.
align_err  output  1  with rx_eof: closing flag not on an octet boundary.
len_err  output  1  with rx_eof: octet count < MIN_BYTES or > MAX_BYTES.
abort  output  1  one-cycle pulse on seven or more consecutive ones.
byte_count  output  8  octets in the ended frame, FCS included; valid with rx_eof.
in_frame  output  1  level, high from first octet until eof/abort.
led_rx_active  output  1  equal to in_frame.

Behaviour:
- Reset: all outputs 0, state HUNT, ones_run 0, crc 0xFFFF.
- Only cycles with rx_bit_en=1 advance the logic. All outputs are registered and appear 1 cycle after the strobe that causes them.
- Line rules per strobe:
  - ones_run counts consecutive raw 1s.
  - Raw 0 with ones_run==5: stuffed bit, dropped, ones_run cleared.
  - Raw 0 with ones_run==6: flag detected.
  - Raw 1 making ones_run==7: abort; ones_run saturates at 7.
  - Any other bit is a data bit and is shifted into the octet register at position bit_cnt; bit_cnt wraps 7->0 on octet completion.
- States:
  - HUNT: discard data bits; on flag go to SYNC; an abort stays in HUNT with no pulse.
  - SYNC (flag seen, no octet yet): clear bit_cnt, byte_count and crc (0xFFFF) on each flag. The first completed octet pulses rx_valid+rx_sof, raises in_frame and moves to DATA. An abort pulses abort and returns to HUNT.
  - DATA: each completed octet pulses rx_valid, updates crc (reflected poly 0x8408, LSB-first) and increments byte_count.
    - Flag: rx_eof pulses. align_err = (bit_cnt != 7) at detection, since the flag's 0+six 1s sit in the partial octet.
    - len_err and crc_err are evaluated as defined on the ports; frame_ok = none of the three errors.
    - Then go to SYNC (shared closing/opening flag), in_frame 0.
  - DATA abort: pulse abort, no rx_eof, in_frame 0, go to HUNT.
- Octet MAX_BYTES+1 completing: rx_valid is suppressed. rx_eof pulses with len_err=1, frame_ok=0, byte_count=MAX_BYTES; go to HUNT.
- Consecutive flags (idle fill, zero-length frame): stay in SYNC, no rx_eof.
- Error-flag priority: all three errors may be set together; frame_ok is their NOR.
- FCS octets are delivered like data; the consumer drops the last two when frame_ok=1.
- A reset mid-frame aborts silently: no rx_eof and no abort pulse.

Decomposition:
- Package ais_hdlc_pkg: HDLC_FLAG=8'h7E, CRC_INIT=16'hFFFF, CRC_POLY_REFL=16'h8408, CRC_GOOD_RESIDUE=16'hF0B8, STUFF_RUN=5, state enum {HUNT,SYNC,DATA}.
- One combinational sub-module ais_crc16_x25_byte (crc_in, data -> crc_out), reusable by the transmitter.

Test Plan:
- Idle 0x7E flags, then octets 0x31..0x39, 0x6E, 0x90, then 0x7E -> 11 rx_valid pulses, sof on 0x31, rx_eof with frame_ok=1, byte_count=11.
- Same frame with 0x35 changed to 0x34 -> rx_eof with crc_err=1, frame_ok=0, byte_count=11.
- Payload 0xFF,0x7E,0x1F (stuffed raw stream) plus valid FCS -> rx_data exactly 0xFF,0x7E,0x1F then FCS; every stuffed 0 dropped; frame_ok=1.
- Mid-frame raw run of eight 1s after 3 octets -> abort pulse, no rx_eof, in_frame=0; the next flag+valid frame is received OK.
- Closing flag inserted 3 bits after an octet boundary -> rx_eof, align_err=1. A valid 3-octet frame (1 data + FCS) -> len_err=1. 65 octets -> rx_eof after octet 64, len_err=1.
- Two frames sharing one flag with rx_bit_en high every cycle, and reset asserted mid-second-frame -> first frame OK; after reset all outputs 0 and no rx_eof.

Source files
------------

// File: rtl/ais_hdlc_pkg.sv
// Shared constants and types for the AIS HDLC link (receiver and transmitter).
package ais_hdlc_pkg;

  localparam logic [7:0]  HDLC_FLAG        = 8'h7E;
  localparam logic [15:0] CRC_INIT         = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL    = 16'h8408;
  localparam logic [15:0] CRC_GOOD_RESIDUE = 16'hF0B8;
  localparam int unsigned STUFF_RUN        = 5;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } hdlc_rx_state_e;

endpackage

// File: rtl/ais_crc16_x25_byte.sv
// One-octet CRC-16/X-25 update, LSB-first, reflected polynomial 0x8408.
module ais_crc16_x25_byte
  import ais_hdlc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/ais_hdlc_receiver.sv
// HDLC receive path: flag/abort detection, zero destuffing, LSB-first octet
// assembly, FCS check and per-frame status reporting.
module ais_hdlc_receiver
  import ais_hdlc_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int MIN_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic       rx_bit_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       align_err,
  output logic       len_err,
  output logic       abort,
  output logic [7:0] byte_count,
  output logic       in_frame,
  output logic       led_rx_active
);

  localparam logic [7:0] MAX_CNT   = 8'(MAX_BYTES);
  localparam logic [7:0] MIN_CNT   = 8'(MIN_BYTES);
  localparam logic [2:0] RUN_STUFF = 3'(STUFF_RUN);
  localparam logic [2:0] RUN_FLAG  = 3'(STUFF_RUN + 1);
  localparam logic [2:0] RUN_ABORT = 3'(STUFF_RUN + 2);

  hdlc_rx_state_e state_q, state_d;
  logic [2:0]  ones_q, ones_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_sof_q, rx_sof_d;
  logic       rx_eof_q, rx_eof_d;
  logic       frame_ok_q, frame_ok_d;
  logic       crc_err_q, crc_err_d;
  logic       align_err_q, align_err_d;
  logic       len_err_q, len_err_d;
  logic       abort_q, abort_d;
  logic [7:0] byte_count_q, byte_count_d;
  logic       in_frame_q, in_frame_d;

  logic        is_stuff, is_flag, is_abort, is_data, octet_done;
  logic        crc_bad, len_bad, align_bad;
  logic [7:0]  octet_full;
  logic [15:0] crc_upd;

  // Line classification of the current raw bit against the run of ones before it.
  assign is_stuff   = rx_bit_en && !rx_bit && (ones_q == RUN_STUFF);
  assign is_flag    = rx_bit_en && !rx_bit && (ones_q == RUN_FLAG);
  assign is_abort   = rx_bit_en &&  rx_bit && (ones_q == RUN_FLAG);
  assign is_data    = rx_bit_en && !(is_stuff || is_flag || is_abort);
  assign octet_done = is_data && (bit_cnt_q == 3'd7);
  assign octet_full = {rx_bit, shreg_q};

  // The flag's leading 0 and six 1s were taken as data, so an aligned
  // closing flag is detected with exactly seven bits in the partial octet.
  assign crc_bad   = (crc_q != CRC_GOOD_RESIDUE);
  assign len_bad   = (cnt_q < MIN_CNT) || (cnt_q > MAX_CNT);
  assign align_bad = (bit_cnt_q != 3'd7);

  ais_crc16_x25_byte u_crc (
    .crc_in  (crc_q),
    .data    (octet_full),
    .crc_out (crc_upd)
  );

  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_sof_d     = 1'b0;
    rx_eof_d     = 1'b0;
    frame_ok_d   = 1'b0;
    crc_err_d    = 1'b0;
    align_err_d  = 1'b0;
    len_err_d    = 1'b0;
    abort_d      = 1'b0;
    byte_count_d = byte_count_q;
    in_frame_d   = in_frame_q;

    if (rx_bit_en) begin
      if (rx_bit) ones_d = (ones_q == RUN_ABORT) ? ones_q : ones_q + 3'd1;
      else        ones_d = 3'd0;

      if (is_data) begin
        if (bit_cnt_q != 3'd7) shreg_d[bit_cnt_q] = rx_bit;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end

      // Every flag restarts octet alignment and the FCS accumulator.
      if (is_flag) begin
        bit_cnt_d = 3'd0;
        cnt_d     = 8'd0;
        crc_d     = CRC_INIT;
      end

      case (state_q)
        HUNT: begin
          if (is_flag) state_d = SYNC;
        end
        SYNC: begin
          if (is_abort) begin
            abort_d = 1'b1;
            state_d = HUNT;
          end else if (octet_done) begin
            rx_valid_d = 1'b1;
            rx_sof_d   = 1'b1;
            rx_data_d  = octet_full;
            crc_d      = crc_upd;
            cnt_d      = 8'd1;
            in_frame_d = 1'b1;
            state_d    = DATA;
          end
        end
        DATA: begin
          if (is_flag) begin
            rx_eof_d     = 1'b1;
            crc_err_d    = crc_bad;
            len_err_d    = len_bad;
            align_err_d  = align_bad;
            frame_ok_d   = !(crc_bad || len_bad || align_bad);
            byte_count_d = cnt_q;
            in_frame_d   = 1'b0;
            state_d      = SYNC;
          end else if (is_abort) begin
            abort_d    = 1'b1;
            in_frame_d = 1'b0;
            state_d    = HUNT;
          end else if (octet_done) begin
            if (cnt_q == MAX_CNT) begin
              // Oversized frame: drop this octet and close the frame here.
              rx_eof_d     = 1'b1;
              len_err_d    = 1'b1;
              crc_err_d    = crc_bad;
              byte_count_d = MAX_CNT;
              in_frame_d   = 1'b0;
              state_d      = HUNT;
            end else begin
              rx_valid_d = 1'b1;
              rx_data_d  = octet_full;
              crc_d      = crc_upd;
              cnt_d      = cnt_q + 8'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      ones_q       <= 3'd0;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 7'd0;
      crc_q        <= CRC_INIT;
      cnt_q        <= 8'd0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_sof_q     <= 1'b0;
      rx_eof_q     <= 1'b0;
      frame_ok_q   <= 1'b0;
      crc_err_q    <= 1'b0;
      align_err_q  <= 1'b0;
      len_err_q    <= 1'b0;
      abort_q      <= 1'b0;
      byte_count_q <= 8'd0;
      in_frame_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ones_q       <= ones_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_sof_q     <= rx_sof_d;
      rx_eof_q     <= rx_eof_d;
      frame_ok_q   <= frame_ok_d;
      crc_err_q    <= crc_err_d;
      align_err_q  <= align_err_d;
      len_err_q    <= len_err_d;
      abort_q      <= abort_d;
      byte_count_q <= byte_count_d;
      in_frame_q   <= in_frame_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_sof        = rx_sof_q;
  assign rx_eof        = rx_eof_q;
  assign frame_ok      = frame_ok_q;
  assign crc_err       = crc_err_q;
  assign align_err     = align_err_q;
  assign len_err       = len_err_q;
  assign abort         = abort_q;
  assign byte_count    = byte_count_q;
  assign in_frame      = in_frame_q;
  assign led_rx_active = in_frame_q;

endmodule
